// File: rtl/wb_grf_pkg.sv
// rtl/wb_grf_pkg.sv - MIPS opcode/funct definitions and field views shared by the stage decoders.
package wb_grf_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;

  localparam logic [4:0] RA_IDX = 5'd31;

  typedef enum logic [1:0] {
    WSRC_NONE,
    WSRC_ALU,
    WSRC_DM,
    WSRC_PC8
  } wsrc_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic instr_t split_instr(input logic [31:0] ir);
    return instr_t'(ir);
  endfunction

endpackage

// File: rtl/wb_dec.sv
// rtl/wb_dec.sv - W-stage write decoder: instruction bundle to GRF write enable, address and data.
module wb_dec
  import wb_grf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]   W_IR,
  input  logic [DW-1:0] W_PC,
  input  logic [DW-1:0] W_DMRD,
  input  logic [DW-1:0] W_ALUO,
  output logic          W_WE,
  output logic [4:0]    W_WA,
  output logic [DW-1:0] W_WD
);

  instr_t        w_f;
  wsrc_e         w_src;
  logic [4:0]    w_wa_raw;
  logic [DW-1:0] w_wd_raw;
  logic          w_unused;

  assign w_f      = split_instr(W_IR);
  assign w_unused = ^{w_f.rs, w_f.shamt};

  always_comb begin
    w_src    = WSRC_NONE;
    w_wa_raw = '0;
    case (w_f.op)
      OP_RTYPE: begin
        case (w_f.funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: begin
            w_src    = WSRC_ALU;
            w_wa_raw = w_f.rd;
          end
          F_JR:    ;
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: begin
        w_src    = WSRC_ALU;
        w_wa_raw = w_f.rt;
      end
      OP_LW: begin
        w_src    = WSRC_DM;
        w_wa_raw = w_f.rt;
      end
      OP_JAL: begin
        w_src    = WSRC_PC8;
        w_wa_raw = RA_IDX;
      end
      OP_SW, OP_BEQ, OP_J: ;
      default: ;
    endcase
  end

  always_comb begin
    w_wd_raw = '0;
    case (w_src)
      WSRC_ALU: w_wd_raw = W_ALUO;
      WSRC_DM:  w_wd_raw = W_DMRD;
      WSRC_PC8: w_wd_raw = W_PC + DW'(8);
      default:  w_wd_raw = '0;
    endcase
  end

  // Writes aimed at $0 are dropped entirely so downstream forwarding never sees them.
  assign W_WE = (w_src != WSRC_NONE) && (w_wa_raw != 5'd0);
  assign W_WA = W_WE ? w_wa_raw : 5'd0;
  assign W_WD = W_WE ? w_wd_raw : '0;

endmodule

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - Writeback stage plus 32x32 general register file with W->D read bypass.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter int          DW       = 32,
  parameter logic [31:0] PC_RESET = 32'h3000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   W_PC,
  input  logic [31:0]   W_IR,
  input  logic [DW-1:0] W_DMRD,
  input  logic [DW-1:0] W_ALUO,
  input  logic [4:0]    D_RS_ADDR,
  input  logic [4:0]    D_RT_ADDR,
  output logic [DW-1:0] D_RS_DATA,
  output logic [DW-1:0] D_RT_DATA,
  output logic          W_WE,
  output logic [4:0]    W_WA,
  output logic [DW-1:0] W_WD
);

  logic [DW-1:0] r_grf [NREG];
  logic          w_we;
  logic [4:0]    w_wa;
  logic [DW-1:0] w_wd;

  wb_dec #(.DW(DW)) u_dec (
    .W_IR   (W_IR),
    .W_PC   (DW'(W_PC)),
    .W_DMRD (W_DMRD),
    .W_ALUO (W_ALUO),
    .W_WE   (w_we),
    .W_WA   (w_wa),
    .W_WD   (w_wd)
  );

  assign W_WE = w_we;
  assign W_WA = w_wa;
  assign W_WD = w_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_grf[i] <= '0;
      end
    end else if (w_we) begin
      r_grf[w_wa] <= w_wd;
    end
  end

  // Bypass is held off during reset so a read then shows the array, not the dropped write.
  function automatic logic [DW-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end else if (w_we && !rst && (addr == w_wa)) begin
      return w_wd;
    end else begin
      return r_grf[addr];
    end
  endfunction

  assign D_RS_DATA = read_port(D_RS_ADDR);
  assign D_RT_DATA = read_port(D_RT_ADDR);

`ifndef SYNTHESIS
  logic [31:0] w_trace_pc;

  // A nop bundle stands for the reset PC; it never writes, so only real PCs are printed.
  assign w_trace_pc = (W_IR == 32'd0) ? PC_RESET : W_PC;

  always @(posedge clk) begin
    if (!rst && w_we) begin
      $display("@%h: $%d <= %h", w_trace_pc, w_wa, w_wd);
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - Self-checking bench for wb_grf against a register-array reference model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] W_PC, W_IR, W_DMRD, W_ALUO;
  logic [4:0]  D_RS_ADDR, D_RT_ADDR;
  logic [31:0] D_RS_DATA, D_RT_DATA;
  logic        W_WE;
  logic [4:0]  W_WA;
  logic [31:0] W_WD;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [32];
  logic [37:0] cur_wr;
  logic        cur_rst;

  wb_grf dut (
    .clk       (clk),
    .rst       (rst),
    .W_PC      (W_PC),
    .W_IR      (W_IR),
    .W_DMRD    (W_DMRD),
    .W_ALUO    (W_ALUO),
    .D_RS_ADDR (D_RS_ADDR),
    .D_RT_ADDR (D_RT_ADDR),
    .D_RS_DATA (D_RS_DATA),
    .D_RT_DATA (D_RT_DATA),
    .W_WE      (W_WE),
    .W_WA      (W_WA),
    .W_WD      (W_WD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of the instruction in W: {we, wa, wd}.
  function automatic logic [37:0] ref_write(input logic [31:0] ir, pc, dm, alu);
    int unsigned op, fn, dest;
    logic [31:0] val;
    op   = ir[31:26];
    fn   = ir[5:0];
    dest = 0;
    val  = 0;
    if (op == 0 && (fn inside {32, 33, 34, 35, 36, 37, 42})) begin
      dest = ir[15:11]; val = alu;
    end else if (op == 13 || op == 15) begin
      dest = ir[20:16]; val = alu;
    end else if (op == 35) begin
      dest = ir[20:16]; val = dm;
    end else if (op == 3) begin
      dest = 31; val = pc + 32'd8;
    end
    if (dest == 0) return 38'd0;
    return {1'b1, dest[4:0], val};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (!cur_rst && cur_wr[37] && a == cur_wr[36:32]) return cur_wr[31:0];
    return model[a];
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int fn);
    logic [31:0] ir;
    ir = $urandom;
    ir[31:26] = 6'd0;
    ir[15:11] = 5'(rd);
    ir[5:0]   = 6'(fn);
    return ir;
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt);
    logic [31:0] ir;
    ir = $urandom;
    ir[31:26] = 6'(op);
    ir[20:16] = 5'(rt);
    return ir;
  endfunction

  task automatic drive(input logic [31:0] ir, pc, dm, alu, input logic [4:0] ra, rb,
                       input logic r, input logic do_check);
    W_IR = ir; W_PC = pc; W_DMRD = dm; W_ALUO = alu;
    D_RS_ADDR = ra; D_RT_ADDR = rb; rst = r;
    cur_wr  = ref_write(ir, pc, dm, alu);
    cur_rst = r;
    #2;
    if (do_check) begin
      check("we", 32'(W_WE), 32'(cur_wr[37]));
      check("wa", 32'(W_WA), 32'(cur_wr[36:32]));
      check("wd", W_WD, cur_wr[31:0]);
      check("rs", D_RS_DATA, ref_read(ra));
      check("rt", D_RT_DATA, ref_read(rb));
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (cur_rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (cur_wr[37]) begin
      model[cur_wr[36:32]] = cur_wr[31:0];
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    int fns [9] = '{32, 33, 34, 35, 36, 37, 42, 8, 39};
    k = $urandom_range(0, 9);
    case (k)
      0, 1:    return enc_r($urandom_range(0, 31), fns[$urandom_range(0, 8)]);
      2:       return enc_i(13, $urandom_range(0, 31));
      3:       return enc_i(15, $urandom_range(0, 31));
      4, 5:    return enc_i(35, $urandom_range(0, 31));
      6:       return enc_i(3, $urandom_range(0, 31));
      7:       return enc_i(43, $urandom_range(0, 31));
      8:       return enc_i(4, $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    W_IR = 0; W_PC = 0; W_DMRD = 0; W_ALUO = 0; D_RS_ADDR = 0; D_RT_ADDR = 0; rst = 1'b1;
    @(negedge clk);
    drive(32'd0, 32'h3000, 0, 0, 0, 0, 1'b1, 1'b0);
    commit();

    // Reset with stale contents, then sweep all addresses.
    drive(enc_i(13, 3), 32'h3000, 0, 32'h11, 0, 0, 1'b0, 1'b1); commit();
    drive(enc_i(35, 20), 32'h3004, 32'h22, 0, 3, 0, 1'b0, 1'b1); commit();
    drive(enc_i(13, 7), 32'h3008, 0, 32'h33, 20, 3, 1'b0, 1'b1); commit();
    drive(32'd0, 32'h300c, 0, 0, 7, 20, 1'b1, 1'b1); commit();
    for (int a = 0; a < 32; a++) begin
      drive(32'd0, 32'h3000, $urandom, $urandom, 5'(a), 5'(31 - a), 1'b0, 1'b1);
      check("rst_rs", D_RS_DATA, 32'd0);
      check("rst_we", 32'(W_WE), 32'd0);
      commit();
    end

    // ori $5
    drive(enc_i(13, 5), 32'h3004, $urandom, 32'h0000_1234, 0, 0, 1'b0, 1'b1);
    check("ori_wa", 32'(W_WA), 32'd5);
    check("ori_wd", W_WD, 32'h1234);
    commit();
    drive(32'd0, 32'h3008, 0, 0, 5, 0, 1'b0, 1'b1);
    check("ori_rd", D_RS_DATA, 32'h1234);
    commit();

    // lw bypass on both ports
    drive(enc_i(35, 8), 32'h300c, 32'hDEAD_BEEF, $urandom, 8, 8, 1'b0, 1'b1);
    check("byp_rs", D_RS_DATA, 32'hDEAD_BEEF);
    check("byp_rt", D_RT_DATA, 32'hDEAD_BEEF);
    commit();

    // $0 guard
    drive(enc_r(0, 33), 32'h3010, 0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b1);
    check("z_we", 32'(W_WE), 32'd0);
    check("z_wa", 32'(W_WA), 32'd0);
    check("z_wd", W_WD, 32'd0);
    commit();
    drive(32'd0, 32'h3014, 0, 0, 0, 0, 1'b0, 1'b1);
    check("z_rd", D_RS_DATA, 32'd0);
    commit();

    // jal wrap, then non-writing instructions
    drive(enc_i(3, 0), 32'hFFFF_FFFC, 0, 0, 31, 0, 1'b0, 1'b1);
    check("jal_wa", 32'(W_WA), 32'd31);
    check("jal_wd", W_WD, 32'h4);
    commit();
    drive(enc_i(43, 8), 32'h3018, $urandom, $urandom, 31, 8, 1'b0, 1'b1); commit();
    drive(enc_i(4, 5), 32'h301c, $urandom, $urandom, 5, 8, 1'b0, 1'b1); commit();
    drive(enc_r(31, 8), 32'h3020, $urandom, $urandom, 31, 5, 1'b0, 1'b1);
    check("jr_ra", D_RS_DATA, 32'h4);
    commit();

    // Reset colliding with a write to $9
    drive(enc_i(13, 9), 32'h3024, 0, 32'h77, 0, 0, 1'b0, 1'b1); commit();
    drive(enc_i(13, 9), 32'h3028, 0, 32'h55, 9, 9, 1'b1, 1'b1);
    check("rst_byp", D_RS_DATA, 32'h77);
    commit();
    drive(32'd0, 32'h3000, 0, 0, 9, 9, 1'b0, 1'b1);
    check("rst_9", D_RS_DATA, 32'd0);
    commit();

    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra, rb;
      ra = 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      drive(rand_instr(), $urandom, $urandom, $urandom, ra, rb,
            ($urandom_range(0, 29) == 0), 1'b1);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
